// File: rtl/spi_reg_ctrl_if.sv
// SPI pin bundle between an SPI master and the spi_reg_ctrl register slave.
// The master drives sclk/copi/ncs; the slave drives cipo/cipo_oe.
interface spi_reg_ctrl_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, copi, ncs, input cipo, cipo_oe);
  modport slave  (input sclk, copi, ncs, output cipo, cipo_oe);
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave that owns the five 8-bit PWM control registers.
// Define SPI_READBACK_EN to enable register readback on cipo.
module spi_reg_ctrl #(
  parameter int MAX_ADDR    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  spi_reg_ctrl_if.slave   spi,
  output logic [7:0]      en_reg_out_7_0,
  output logic [7:0]      en_reg_out_15_8,
  output logic [7:0]      en_reg_pwm_7_0,
  output logic [7:0]      en_reg_pwm_15_8,
  output logic [7:0]      pwm_duty_cycle,
  output logic            frame_err
);
  localparam int         NUM_REGS   = 5;
  localparam logic [6:0] MAX_ADDR_L = 7'(MAX_ADDR);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_reg, copi_sync_reg, ncs_sync_reg;
  logic                   sclk_d_reg, ncs_d_reg;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_rise, ncs_fall, ncs_edge;

  state_t      state_reg, state_next;
  logic [15:0] shift_reg, shift_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;
  logic        frame_err_reg, frame_err_next;
  logic        commit_write, commit_read;
  logic [7:0]  reg_val [NUM_REGS];

  // ncs resets high so a reset never fabricates a chip-select edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_reg <= '0;
      copi_sync_reg <= '0;
      ncs_sync_reg  <= '1;
      sclk_d_reg    <= 1'b0;
      ncs_d_reg     <= 1'b1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi.sclk};
      copi_sync_reg <= {copi_sync_reg[SYNC_STAGES-2:0], spi.copi};
      ncs_sync_reg  <= {ncs_sync_reg[SYNC_STAGES-2:0], spi.ncs};
      sclk_d_reg    <= sclk_s;
      ncs_d_reg     <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign copi_s    = copi_sync_reg[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign ncs_rise  = ncs_s & ~ncs_d_reg;
  assign ncs_fall  = ~ncs_s & ncs_d_reg;
  assign ncs_edge  = ncs_rise | ncs_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      bit_cnt_reg   <= bit_cnt_next;
      frame_err_reg <= frame_err_next;
    end
  end

  assign commit_write = (state_reg == COMMIT) && (bit_cnt_reg == 5'd16) &&
                        shift_reg[15] && (shift_reg[14:8] <= MAX_ADDR_L);
  assign commit_read  = (state_reg == COMMIT) && (bit_cnt_reg == 5'd16) && !shift_reg[15];

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt_reg;
    frame_err_next = (state_reg == COMMIT) && !commit_write && !commit_read;
    case (state_reg)
      IDLE: begin
        if (ncs_fall) begin
          state_next   = SHIFT;
          shift_next   = '0;
          bit_cnt_next = '0;
        end
      end
      SHIFT: begin
        // sclk edges landing on a chip-select edge are not data
        if (ncs_rise) begin
          state_next = COMMIT;
        end else if (sclk_rise && !ncs_edge) begin
          shift_next = {shift_reg[14:0], copi_s};
          if (bit_cnt_reg != 5'd17) bit_cnt_next = bit_cnt_reg + 5'd1;
        end
      end
      COMMIT: begin
        state_next = IDLE;
        if (ncs_fall) begin
          state_next   = SHIFT;
          shift_next   = '0;
          bit_cnt_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [7:0] val_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        val_reg <= '0;
      else if (commit_write && shift_reg[14:8] == 7'(gi))
        val_reg <= shift_reg[7:0];
    end
    assign reg_val[gi] = val_reg;
  end

  assign en_reg_out_7_0  = reg_val[0];
  assign en_reg_out_15_8 = reg_val[1];
  assign en_reg_pwm_7_0  = reg_val[2];
  assign en_reg_pwm_15_8 = reg_val[3];
  assign pwm_duty_cycle  = reg_val[4];
  assign frame_err       = frame_err_reg;

`ifdef SPI_READBACK_EN
  logic [7:0] tx_reg;
  logic [7:0] rd_data;
  logic [6:0] rd_addr;
  logic       sclk_fall, tx_load, tx_shift;

  assign sclk_fall = ~sclk_s & sclk_d_reg;
  // address is complete on the 8th rising edge: old shift[5:0] plus the incoming bit
  assign rd_addr   = {shift_reg[5:0], copi_s};
  assign tx_load   = (state_reg == SHIFT) && sclk_rise && !ncs_edge &&
                     (bit_cnt_reg == 5'd7) && !shift_reg[6];
  assign tx_shift  = (state_reg == SHIFT) && sclk_fall && !ncs_edge &&
                     (bit_cnt_reg >= 5'd9) && (bit_cnt_reg <= 5'd15);

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_addr == 7'(i)) rd_data = reg_val[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tx_reg <= '0;
    else if (ncs_fall || state_reg == COMMIT)
      tx_reg <= '0;
    else if (tx_load)
      tx_reg <= rd_data;
    else if (tx_shift)
      tx_reg <= {tx_reg[6:0], 1'b0};
  end

  assign spi.cipo    = tx_reg[7];
  assign spi.cipo_oe = ~ncs_s;
`else
  assign spi.cipo    = 1'b0;
  assign spi.cipo_oe = 1'b0;
`endif
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Table-driven bench for spi_reg_ctrl with a scoreboard of expected commit results.
// Reset-mid-frame and readback checks are hand-written sequences.
module tb_spi_reg_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic frame_err;
  logic [39:0] dut_regs;

  spi_reg_ctrl_if spi ();

  spi_reg_ctrl #(.MAX_ADDR(4), .SYNC_STAGES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .spi             (spi.slave),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  assign dut_regs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};

  typedef struct {
    string       name;
    logic [16:0] bits;
    int          n;
    logic [39:0] regs;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [39:0] regs;
    logic        err;
  } exp_t;

  localparam int HALF = 8;

  vec_t        vecs [13];
  exp_t        sb [$];
  logic [39:0] last_regs;
  int          tests = 0;
  int          fails = 0;
  int          err_pulses = 0;
  int          exp_pulses = 0;

  always @(negedge clk) if (!rst && frame_err === 1'b1) err_pulses++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // drives bits[n-1:0] MSB first; checks cipo/cipo_oe before each rising sclk
  task automatic shift_bits(input logic [16:0] bits, input int n, input logic rd, input logic [7:0] rdval);
    int k = 0;
    for (int i = n - 1; i >= 0; i--) begin
      spi.copi = bits[i];
      repeat (HALF) @(negedge clk);
`ifdef SPI_READBACK_EN
      chk("cipo_oe_low_ncs", {63'd0, spi.cipo_oe}, 64'd1);
      if (rd && k >= 8) chk("cipo_bit", {63'd0, spi.cipo}, {63'd0, rdval[15-k]});
`else
      chk("cipo_tied", {62'd0, spi.cipo, spi.cipo_oe}, 64'd0);
`endif
      spi.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi.sclk = 1'b0;
      k++;
    end
  endtask

  task automatic run_frame(input vec_t v);
    logic       rd;
    logic [6:0] addr;
    logic [7:0] rdval;
    exp_t       e;
    sb.push_back('{regs: v.regs, err: v.err});
    rd    = (v.n == 16) && !v.bits[15];
    addr  = v.bits[14:8];
    rdval = (addr < 7'd5) ? last_regs[int'(addr)*8 +: 8] : 8'h00;
    @(negedge clk);
    spi.ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    shift_bits(v.bits, v.n, rd, rdval);
    repeat (HALF) @(negedge clk);
    spi.ncs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk({v.name, "_hold_edge3"}, {24'd0, dut_regs}, {24'd0, last_regs});
    chk({v.name, "_err_edge3"}, {63'd0, frame_err}, 64'd0);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({v.name, "_regs"}, {24'd0, dut_regs}, {24'd0, e.regs});
    chk({v.name, "_err"}, {63'd0, frame_err}, {63'd0, e.err});
    @(posedge clk);
    #1;
    chk({v.name, "_err_1clk"}, {63'd0, frame_err}, 64'd0);
    chk({v.name, "_oe_idle"}, {63'd0, spi.cipo_oe}, 64'd0);
    $display("[TB] frame %s nbits=%0d regs=%h frame_err=%0d", v.name, v.n, dut_regs, e.err);
    last_regs = e.regs;
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{"wr_r0_ff",    17'h080FF, 16, 40'h00_00_00_00_FF, 1'b0};
    vecs[1]  = '{"wr_r4_80",    17'h08480, 16, 40'h80_00_00_00_FF, 1'b0};
    vecs[2]  = '{"wr_a5_drop",  17'h085AA, 16, 40'h80_00_00_00_FF, 1'b1};
    vecs[3]  = '{"short15",     17'h04099, 15, 40'h80_00_00_00_FF, 1'b1};
    vecs[4]  = '{"long17",      17'h10155, 17, 40'h80_00_00_00_FF, 1'b1};
    vecs[5]  = '{"rd_r0",       17'h00000, 16, 40'h80_00_00_00_FF, 1'b0};
    vecs[6]  = '{"wr_r1_55",    17'h08155, 16, 40'h80_00_00_55_FF, 1'b0};
    vecs[7]  = '{"wr_r3_3c",    17'h0833C, 16, 40'h80_3C_00_55_FF, 1'b0};
    vecs[8]  = '{"rd_r3",       17'h00300, 16, 40'h80_3C_00_55_FF, 1'b0};
    vecs[9]  = '{"rd_unmapped", 17'h00700, 16, 40'h80_3C_00_55_FF, 1'b0};
    vecs[10] = '{"empty0",      17'h00000, 0,  40'h80_3C_00_55_FF, 1'b1};
    vecs[11] = '{"wr_a7f_drop", 17'h0FF01, 16, 40'h80_3C_00_55_FF, 1'b1};
    vecs[12] = '{"wr_r4_00",    17'h08400, 16, 40'h00_3C_00_55_FF, 1'b0};

    rst = 1'b1;
    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    spi.ncs  = 1'b1;
    last_regs = '0;
    repeat (4) @(negedge clk);
    chk("reset_regs", {24'd0, dut_regs}, 64'd0);
    chk("reset_err", {63'd0, frame_err}, 64'd0);
    chk("reset_cipo", {62'd0, spi.cipo, spi.cipo_oe}, 64'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    foreach (vecs[i]) begin
      run_frame(vecs[i]);
      if (vecs[i].err) exp_pulses++;
    end
    chk("err_pulse_total", 64'(err_pulses), 64'(exp_pulses));

    // reset lands after 10 bits of a write to reg 0x02
    @(negedge clk);
    spi.ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    shift_bits(17'h082A5 >> 6, 10, 1'b0, 8'h00);
    repeat (HALF / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midframe_rst_regs", {24'd0, dut_regs}, 64'd0);
    chk("midframe_rst_err", {63'd0, frame_err}, 64'd0);
    @(negedge clk);
    spi.ncs = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_commit_after_rst", {24'd0, dut_regs}, 64'd0);
    chk("no_err_after_rst", 64'(err_pulses), 64'(exp_pulses));
    $display("[TB] frame midframe_reset regs=%h", dut_regs);
    last_regs = '0;
    run_frame('{"wr_r2_5a", 17'h0825A, 16, 40'h00_00_5A_00_00, 1'b0});

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
